cubic_seq: RTL and testbench

//  Multi-cycle evaluator of f(x) = 0.85*x^3 + 1. Input is signed fix<10,7>; output is signed fix<10,6>.
//  The three multiplies run in sequence on ONE shared 11x11 signed multiplier, so the block replaces

---
 rtl/cubic_seq.sv | 171 +++++++++++++++++
 tb/tb_cubic_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cubic_seq.sv
// cubic_seq: multi-cycle evaluator of f(x) = 0.85*x^3 + 1.
// Input x is signed fix<10,7>, result is signed fix<10,6>. The three products
// are computed in sequence on a single shared 11x11 signed multiplier whose
// operands are selected by the FSM state. Overflow zeroes the result, raises
// out_ovf and bumps a saturating event counter.
module cubic_seq #(
  parameter int unsigned CONST_SCALE = 435,  // 0.85 as unsigned fix<10,9>
  parameter int unsigned CONST_ONE   = 64,   // 1.0 as fix<10,6>
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [9:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [9:0]       out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int unsigned DW = 10;
  localparam int unsigned MW = 11;
  localparam int unsigned PW = 22;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SQ   = 3'd1;
  localparam logic [2:0] S_CU   = 3'd2;
  localparam logic [2:0] S_CM   = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    x_q, x_d;
  logic [DW-1:0]    sq_q, sq_d;
  logic [DW-1:0]    cu_q, cu_d;
  logic             ovf_sq_q, ovf_sq_d;
  logic             ovf_cu_q, ovf_cu_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic signed [MW-1:0] mul_a, mul_b;
  logic signed [PW-1:0] prod;
  logic [DW-1:0]        cm10;
  logic [DW:0]          sum_r;
  logic                 ovf_c;
  logic                 unused_prod;

  // Shared multiplier operand select, driven by the current phase
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_SQ: begin
        mul_a = {x_q[DW-1], x_q};
        mul_b = {x_q[DW-1], x_q};
      end
      S_CU: begin
        mul_a = {1'b0, sq_q};
        mul_b = {x_q[DW-1], x_q};
      end
      S_CM: begin
        mul_a = {cu_q[DW-1], cu_q};
        mul_b = {1'b0, DW'(CONST_SCALE)};
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  // The single multiplier instance
  assign prod = PW'(mul_a) * PW'(mul_b);

  // Scale-and-offset stage: drop to <10,6>, add 1.0, detect 10-bit wrap
  always_comb begin
    cm10  = prod[18:9];
    sum_r = {cm10[DW-1], cm10} + (DW+1)'(CONST_ONE);
    ovf_c = ovf_sq_q | ovf_cu_q | (sum_r[DW] ^ sum_r[DW-1]);
  end

  // Fractional bits below the <10,7> square alignment never reach a result
  assign unused_prod = ^prod[6:0];

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    sq_d        = sq_q;
    cu_d        = cu_q;
    ovf_sq_d    = ovf_sq_q;
    ovf_cu_d    = ovf_cu_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    ovf_cnt_d   = ovf_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          state_d = S_SQ;
        end
      end
      S_SQ: begin
        sq_d     = prod[16:7];
        ovf_sq_d = |prod[21:17];
        state_d  = S_CU;
      end
      S_CU: begin
        cu_d     = prod[17:8];
        ovf_cu_d = ~((prod[21:17] == 5'b00000) | (prod[21:17] == 5'b11111));
        state_d  = S_CM;
      end
      S_CM: begin
        out_data_d  = ovf_c ? '0 : sum_r[DW-1:0];
        out_ovf_d   = ovf_c;
        out_valid_d = 1'b1;
        if (ovf_c && (ovf_cnt_q != {CNT_W{1'b1}})) begin
          ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      sq_q        <= '0;
      cu_q        <= '0;
      ovf_sq_q    <= 1'b0;
      ovf_cu_q    <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      sq_q        <= sq_d;
      cu_q        <= cu_d;
      ovf_sq_q    <= ovf_sq_d;
      ovf_cu_q    <= ovf_cu_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_cubic_seq.sv
// Scoreboard bench for cubic_seq: the driver pushes the expected result on
// every accept, an independent monitor pops and compares on every output
// handshake. Random vectors use an integer-arithmetic reference of f(x).
module tb_cubic_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] out_data;
  logic       out_ovf;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] ovf_cnt;

  cubic_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] data;
    logic       ovf;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  int   last_hs_cyc = 0;
  bit   mon_en = 1'b0;
  bit   front_seen = 1'b0;
  bit   hs_prev = 1'b0;
  bit   chk_gap = 1'b0;
  bit   rdy_val = 1'b1;
  bit   rdy_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference f(x) from plain integer arithmetic on the fixed-point values
  function automatic void model(input logic [9:0] xin, output logic [9:0] d, output logic o);
    int x, sq, sq10, p, cu, cm, r;
    bit ov;
    x    = int'($signed(xin));
    sq   = x * x;
    ov   = (sq >= 131072);
    sq10 = (sq / 128) % 1024;
    p    = sq10 * x;
    if (p >= 131072 || p < -131072) ov = 1'b1;
    cu   = p >>> 8;
    cm   = (cu * 435) >>> 9;
    r    = cm + 64;
    if (r > 511 || r < -512) ov = 1'b1;
    d = ov ? 10'd0 : 10'(r);
    o = ov;
  endfunction

  // Consumer ready: fixed level or random backpressure
  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  // Monitor: compare the presented result against the scoreboard head
  always @(negedge clk) begin
    if (mon_en) begin
      if (hs_prev) begin
        check("post_hs_in_ready", int'(in_ready), 1);
        check("post_hs_valid_low", int'(out_valid), 0);
        hs_prev = 1'b0;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stale_valid", int'(out_valid), 0);
        end else begin
          if (!front_seen) begin
            check("latency", cyc - exp_q[0].acc, 4);
            front_seen = 1'b1;
          end
          check("out_data", int'(out_data), int'(exp_q[0].data));
          check("out_ovf", int'(out_ovf), int'(exp_q[0].ovf));
          check("in_ready_busy", int'(in_ready), 0);
          if (out_ready) begin
            if (exp_q[0].ovf && model_cnt < 255) model_cnt++;
            check("ovf_cnt", int'(ovf_cnt), model_cnt);
            void'(exp_q.pop_front());
            front_seen  = 1'b0;
            hs_prev     = 1'b1;
            last_hs_cyc = cyc;
          end
        end
      end
    end
  end

  // Offer x until accepted; expected result enters the scoreboard on accept
  task automatic send(input logic [9:0] x, input logic [9:0] ed, input logic eo);
    int   n;
    exp_t e;
    n        = 0;
    in_data  = x;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", int'(in_ready), 1);
    end else begin
      if (chk_gap) check("accept_gap", cyc - last_hs_cyc, 1);
      e.data = ed;
      e.ovf  = eo;
      e.acc  = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 10'($urandom);
  endtask

  task automatic send_model(input logic [9:0] x);
    logic [9:0] d;
    logic       o;
    model(x, d, o);
    send(x, d, o);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int v;
    logic [9:0] x;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    check("rst_ovf_cnt", int'(ovf_cnt), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk);
    #1;

    // Directed points with hand-derived results
    send(10'h000, 10'd64, 1'b0);
    send(10'h080, 10'd118, 1'b0);
    send(10'h380, 10'h009, 1'b0);
    send(10'h0C0, 10'd247, 1'b0);
    send(10'h100, 10'd0, 1'b1);
    send(10'h200, 10'd0, 1'b1);
    drain();
    @(negedge clk);
    check("ovf_cnt_after_directed", int'(ovf_cnt), 2);
    @(posedge clk);
    #1;

    // Backpressure: hold result 3 cycles, next sample waiting on release
    rdy_val = 1'b0;
    send(10'h0C0, 10'd247, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("stall_valid_seen", int'(out_valid), 1);
    repeat (3) @(negedge clk);
    rdy_val = 1'b1;
    chk_gap = 1'b1;
    send(10'h380, 10'h009, 1'b0);
    chk_gap = 1'b0;
    drain();

    // Reset while in CU discards the sample
    send(10'h100, 10'd0, 1'b1);
    @(posedge clk);
    #1;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_out_ovf", int'(out_ovf), 0);
    check("midrst_ovf_cnt", int'(ovf_cnt), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    model_cnt  = 0;
    front_seen = 1'b0;
    hs_prev    = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    check("postrst_in_ready", int'(in_ready), 1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;

    // Random samples with random input gaps and consumer backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_model(10'($urandom));
    end
    drain();
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;

    // Counter saturation with 2^8+2 overflowing samples
    for (int i = 0; i < 258; i++) begin
      if ($urandom_range(0, 1) == 1) v = int'($urandom_range(257, 511));
      else v = -int'($urandom_range(257, 512));
      x = 10'(v);
      send(x, 10'd0, 1'b1);
    end
    drain();
    @(negedge clk);
    check("ovf_cnt_saturated", int'(ovf_cnt), 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
